// File: rtl/ov5640_line_pkg.sv
// Shared definitions for the ov5640 line serializer and line collector.
package ov5640_line_pkg;

   localparam int unsigned DEF_LINE_W  = 320;
   localparam int unsigned DEF_ROWS    = 240;
   localparam int unsigned DEF_GAP_CYC = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned COL_W = width_of(DEF_LINE_W);
   localparam int unsigned ROW_W = width_of(DEF_ROWS);

endpackage

// File: rtl/line_serializer.sv
// Accepts a full binary line and feeds it to the filter one pixel per cycle,
// followed by a flush gap; counts rows and flags end of frame.
module line_serializer
   import ov5640_line_pkg::*;
#(
   parameter  int unsigned LINE_W  = DEF_LINE_W,
   parameter  int unsigned ROWS    = DEF_ROWS,
   parameter  int unsigned GAP_CYC = DEF_GAP_CYC,
   localparam int unsigned W_COL   = width_of(LINE_W),
   localparam int unsigned W_ROW   = width_of(ROWS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              abort,
   input  logic [LINE_W-1:0] line_in,
   input  logic              line_valid,
   output logic              line_ready,
   output logic              pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_first,
   output logic              pix_last,
   output logic [W_COL-1:0]  col_idx,
   output logic [W_ROW-1:0]  row_idx,
   output logic              frame_done,
   output logic [1:0]        dbg_state
);

   localparam int unsigned      W_GAP    = width_of(GAP_CYC);
   localparam logic [W_COL-1:0] COL_LAST = W_COL'(LINE_W - 1);
   localparam logic [W_ROW-1:0] ROW_LAST = W_ROW'(ROWS - 1);
   localparam logic [W_GAP-1:0] GAP_LAST = W_GAP'(GAP_CYC - 1);

   state_e            r_state;
   state_e            w_next;
   logic [LINE_W-1:0] r_shift;
   logic [W_COL-1:0]  r_col;
   logic [W_ROW-1:0]  r_row;
   logic [W_GAP-1:0]  r_gap;
   logic              r_ready;
   logic              r_frame_end;
   logic              r_frame_done;
   logic              w_accept;
   logic              w_xfer;
   logic              w_line_end;
   logic              w_gap_end;
   logic              w_eol;

   // Both handshakes transfer on a rising edge where valid and ready are high;
   // a producer holding valid keeps its payload stable until that edge.
   assign w_accept   = line_valid && line_ready;
   assign w_xfer     = (r_state == ST_SHIFT) && pix_ready;
   assign w_line_end = w_xfer && (r_col == COL_LAST);
   assign w_gap_end  = (r_state == ST_GAP) && (r_gap == GAP_LAST);
   // First IDLE cycle after a line: ready_q is still low, end-of-line work happens here.
   assign w_eol      = (r_state == ST_IDLE) && !r_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_accept)   w_next = ST_SHIFT;
            ST_SHIFT: if (w_line_end) w_next = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (w_gap_end)  w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift      <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_gap        <= '0;
         r_ready      <= 1'b0;
         r_frame_end  <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (abort) begin
         r_col        <= '0;
         r_row        <= '0;
         r_gap        <= '0;
         r_ready      <= 1'b1;
         r_frame_end  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_eol && r_frame_end;
         if (w_eol) begin
            r_ready     <= 1'b1;
            r_frame_end <= 1'b0;
         end
         if (w_accept) begin
            r_shift <= line_in;
            r_col   <= '0;
            r_ready <= 1'b0;
         end
         if (w_xfer) begin
            r_shift <= r_shift >> 1;
            if (w_line_end) begin
               r_col       <= '0;
               r_gap       <= '0;
               r_row       <= (r_row == ROW_LAST) ? '0 : r_row + W_ROW'(1);
               r_frame_end <= (r_row == ROW_LAST);
            end else begin
               r_col <= r_col + W_COL'(1);
            end
         end
         if (r_state == ST_GAP) r_gap <= r_gap + W_GAP'(1);
      end
   end

   always_comb begin
      line_ready = r_ready && !abort;
      pix_valid  = (r_state == ST_SHIFT);
      pix_data   = (r_state == ST_SHIFT) && r_shift[0];
      pix_first  = (r_state == ST_SHIFT) && (r_col == '0);
      pix_last   = (r_state == ST_SHIFT) && (r_col == COL_LAST);
      col_idx    = r_col;
      row_idx    = r_row;
      frame_done = r_frame_done;
      dbg_state  = r_state;
   end

endmodule

// File: tb/tb_line_serializer.sv
// Randomized scoreboard bench for line_serializer with a small line and frame.
module tb_line_serializer;

   localparam int LW     = 8;
   localparam int ROWS_T = 3;
   localparam int GAP_T  = 2;
   localparam int CW     = 3;
   localparam int RW     = 2;
   localparam int REC_W  = RW + CW + 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          abort = 1'b0;
   logic [LW-1:0] line_in = '0;
   logic          line_valid = 1'b0;
   logic          line_ready, pix_data, pix_valid, pix_first, pix_last, frame_done;
   logic          pix_ready = 1'b0;
   logic [CW-1:0] col_idx;
   logic [RW-1:0] row_idx;
   logic [1:0]    dbg_state;

   logic          abort0 = 1'b0;
   logic [LW-1:0] line_in0 = '0;
   logic          line_valid0 = 1'b0;
   logic          pix_ready0 = 1'b0;
   logic          line_ready0, pix_data0, pix_valid0, pix_first0, pix_last0, frame_done0;
   logic [CW-1:0] col_idx0;
   logic [RW-1:0] row_idx0;
   logic [1:0]    dbg_state0;

   int n_checks = 0;
   int n_errors = 0;
   int rdy_mode = 0;
   int m_row = 0;
   int exp_frames = 0;
   int got_frames = 0;
   logic [REC_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   line_serializer #(.LINE_W(LW), .ROWS(ROWS_T), .GAP_CYC(GAP_T)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort), .line_in(line_in),
      .line_valid(line_valid), .line_ready(line_ready), .pix_data(pix_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_first(pix_first),
      .pix_last(pix_last), .col_idx(col_idx), .row_idx(row_idx),
      .frame_done(frame_done), .dbg_state(dbg_state)
   );

   line_serializer #(.LINE_W(LW), .ROWS(ROWS_T), .GAP_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .abort(abort0), .line_in(line_in0),
      .line_valid(line_valid0), .line_ready(line_ready0), .pix_data(pix_data0),
      .pix_valid(pix_valid0), .pix_ready(pix_ready0), .pix_first(pix_first0),
      .pix_last(pix_last0), .col_idx(col_idx0), .row_idx(row_idx0),
      .frame_done(frame_done0), .dbg_state(dbg_state0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a line produces LINE_W pixels, column k carries bit k,
   // tagged with the row the line occupies in the frame.
   task automatic model_accept(input logic [LW-1:0] d);
      for (int k = 0; k < LW; k++)
         exp_q.push_back({RW'(m_row), k == LW - 1, k == 0, CW'(k), d[k]});
      m_row = (m_row + 1) % ROWS_T;
   endtask

   task automatic send_line(input logic [LW-1:0] d);
      int n;
      n = 0;
      @(posedge clk); #1;
      line_in    = d;
      line_valid = 1'b1;
      @(negedge clk);
      while (!line_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!line_ready) begin
         check("accept_timeout", 32'(line_ready), 32'd1);
      end else begin
         model_accept(d);
      end
      @(posedge clk); #1;
      line_valid = 1'b0;
      line_in    = LW'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && line_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(exp_q.size() == 0 && line_ready), 32'd1);
   endtask

   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       pix_ready = 1'b1;
            1:       begin pix_ready = (ph % 3 == 0); ph++; end
            default: pix_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the expected pixel on every transfer, checks stalled outputs hold.
   logic             hold_v = 1'b0;
   logic [REC_W:0]   hold_val;
   logic             prev_fd = 1'b0;
   always @(negedge clk) begin
      logic [REC_W-1:0] act, exp_r;
      act = {row_idx, pix_last, pix_first, col_idx, pix_data};
      if (!rst_n || abort) begin
         hold_v  = 1'b0;
         prev_fd = 1'b0;
      end else begin
         if (hold_v) check("hold", 32'({pix_valid, act}), 32'(hold_val));
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL pixel: got %0h expected none", act);
            end else begin
               exp_r = exp_q.pop_front();
               check("pixel", 32'(act), 32'(exp_r));
               if (exp_r[CW+2] && exp_r[REC_W-1 -: RW] == RW'(ROWS_T - 1)) exp_frames++;
            end
            hold_v = 1'b0;
         end else if (pix_valid) begin
            hold_v   = 1'b1;
            hold_val = {1'b1, act};
         end else begin
            hold_v = 1'b0;
         end
         if (frame_done) begin
            got_frames++;
            check("fd_width", 32'(prev_fd), 32'd0);
            check("fd_row", 32'(row_idx), 32'd0);
            check("fd_ready", 32'(line_ready), 32'd1);
         end
         prev_fd = frame_done;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [LW-1:0] d;
      int acc[$];

      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", 32'({line_ready, pix_valid, pix_data, pix_first, pix_last,
                               frame_done, col_idx, row_idx}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_reset", 32'(line_ready), 32'd1);

      // Known line, pix_ready high: accept-to-ready is LINE_W + GAP + 2 cycles.
      rdy_mode = 0;
      send_line(8'b1011_0010);
      n = 1;
      @(negedge clk);
      while (!line_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("line_period", 32'(n), 32'(LW + GAP_T + 2));

      rdy_mode = 1;
      repeat (3) send_line(LW'($urandom));
      rdy_mode = 2;
      repeat (4) send_line(LW'($urandom));
      rdy_mode = 0;
      repeat (4) send_line(LW'($urandom));
      wait_idle();

      // Abort at column 4 of a line sitting in row 1.
      send_line(LW'($urandom));
      send_line(LW'($urandom));
      n = 0;
      @(posedge clk); #1;
      while (!(pix_valid && col_idx == CW'(4)) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_col_reached", 32'(col_idx), 32'd4);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
      m_row = 0;
      @(negedge clk);
      check("abort_valid", 32'(pix_valid), 32'd0);
      check("abort_row", 32'(row_idx), 32'd0);
      check("abort_ready", 32'(line_ready), 32'd1);
      send_line(LW'($urandom));
      wait_idle();

      // abort and line_valid together: masked, then accepted once abort drops.
      @(posedge clk); #1;
      d = LW'($urandom);
      abort      = 1'b1;
      line_valid = 1'b1;
      line_in    = d;
      m_row      = 0;
      @(negedge clk);
      check("abort_mask_ready", 32'(line_ready), 32'd0);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_no_pix", 32'(pix_valid), 32'd0);
      check("post_abort_ready", 32'(line_ready), 32'd1);
      model_accept(d);
      @(posedge clk); #1;
      line_valid = 1'b0;
      wait_idle();

      // Zero-gap instance with line_valid held: accept-to-accept is LINE_W + 2.
      @(posedge clk); #1;
      line_in0    = LW'($urandom);
      line_valid0 = 1'b1;
      pix_ready0  = 1'b1;
      for (int k = 0; k < 100 && acc.size() < 3; k++) begin
         @(negedge clk);
         if (line_valid0 && line_ready0) acc.push_back(k);
      end
      check("gap0_accepts", 32'(acc.size()), 32'd3);
      if (acc.size() == 3) begin
         check("gap0_period_a", 32'(acc[1] - acc[0]), 32'(LW + 2));
         check("gap0_period_b", 32'(acc[2] - acc[1]), 32'(LW + 2));
      end
      n = 0;
      @(posedge clk); #1;
      while (!(pix_valid0 && col_idx0 == CW'(3)) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("gap0_midline", 32'(pix_valid0), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset_outs", 32'({line_ready0, pix_valid0, pix_data0, pix_first0, pix_last0,
                                     frame_done0, col_idx0, row_idx0}), 32'd0);
      line_valid0 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("gap0_ready_after_reset", 32'(line_ready0), 32'd1);

      repeat (3) @(negedge clk);
      check("frames", 32'(got_frames), 32'(exp_frames));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
